// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode bundle: imem address/data, decode head entry, stall and redirect.
// Handshake: decode takes the head on a cycle where ValidD=1 and StallD=0; RedirectE overrides both.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   PCF;
    logic [31:0]   InstrF;
    logic [31:0]   InstrD;
    logic [31:0]   PCD;
    logic [31:0]   PCPlus4D;
    logic          ValidD;
    logic          StallD;
    logic          RedirectE;
    logic [31:0]   PCTargetE;
    logic [CW-1:0] CountF;

    modport master (
        output PCF, InstrD, PCD, PCPlus4D, ValidD, CountF,
        input  InstrF, StallD, RedirectE, PCTargetE
    );

    modport slave (
        input  PCF, InstrD, PCD, PCPlus4D, ValidD, CountF,
        output InstrF, StallD, RedirectE, PCTargetE
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched entries; flush empties it in one edge.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  T                           i_wdata,
    output T                           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Data storage carries no reset; readers only look at it while count is non-zero.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, buffers fetched words and presents the head entry to decode.
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.master bus
);
    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   r_pc;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_valid;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_wdata;
    fetch_entry_t  w_head;

    assign w_valid = !w_empty;
    // A redirect flushes the head rather than handing it to decode.
    assign w_pop   = w_valid && !bus.StallD && !bus.RedirectE;
    assign w_push  = !bus.RedirectE && (!w_full || w_pop);

    assign w_wdata.instr    = bus.InstrF;
    assign w_wdata.pc       = r_pc;
    assign w_wdata.pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (bus.RedirectE) begin
            r_pc <= bus.PCTargetE;
        end else if (w_push) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.RedirectE),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.PCF      = r_pc;
    assign bus.ValidD   = w_valid;
    assign bus.InstrD   = w_valid ? w_head.instr    : NOP_INSTR;
    assign bus.PCD      = w_valid ? w_head.pc       : 32'h0;
    assign bus.PCPlus4D = w_valid ? w_head.pc_plus4 : 32'h0;
    assign bus.CountF   = w_count;

endmodule
